atan_arbiter: RTL and testbench

ATAN_ARBITER -- requirements
Module: atan_arbiter

---
 rtl/atan_pkg.sv | 63 ++++++
 rtl/atan_step.sv | 52 +++++
 rtl/atan_arbiter.sv | 133 +++++++++++++
 tb/tb_atan_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atan_pkg.sv
// ---------------------------------------------------------------------------
// atan_pkg
// Shared definitions for the round-robin CORDIC arctangent engine.
//   ATAN_ITER_DEFAULT : default number of micro-rotations per request
//   ATAN_ZW_DEFAULT   : default x/y/z datapath width
//   atan_state_t      : controller states (IDLE, RUN, DONE)
//   ATAN_TABLE        : arctan(2^-i) in degrees, 8 integer + 32 fraction
//                       bits, truncated toward zero, i = 0..37
// ---------------------------------------------------------------------------
package atan_pkg;

    localparam int ATAN_ITER_DEFAULT = 38;
    localparam int ATAN_ZW_DEFAULT   = 40;
    localparam int ATAN_ENTRIES      = 38;
    localparam int ATAN_IDX_W        = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } atan_state_t;

    typedef logic [ATAN_ENTRIES-1:0][39:0] atan_table_t;

    // Builds the angle table at elaboration time. Entry 0 is exactly 45
    // degrees; the rest come from the Taylor series of arctan, which
    // converges fast because the argument is at most 0.5. The scaled value
    // is floored so every entry is the truncated fixed-point angle.
    function automatic atan_table_t atanBuildTable();
        atan_table_t tbl;
        real         x;
        real         x2;
        real         term;
        real         rad;
        real         scaled;
        longint      fixedVal;
        tbl = '0;
        x   = 1.0;
        for (int i = 0; i < ATAN_ENTRIES; i++) begin
            if (i == 0) begin
                scaled = 45.0 * 4294967296.0;
            end else begin
                x2   = x * x;
                term = x;
                rad  = 0.0;
                for (int k = 0; k < 32; k++) begin
                    if ((k % 2) == 0) rad = rad + term / real'(2 * k + 1);
                    else              rad = rad - term / real'(2 * k + 1);
                    term = term * x2;
                end
                scaled = rad * 57.29577951308232 * 4294967296.0;
            end
            fixedVal = longint'(scaled);
            if (real'(fixedVal) > scaled) fixedVal = fixedVal - 1;
            tbl[i] = fixedVal[39:0];
            x = x * 0.5;
        end
        return tbl;
    endfunction

    localparam atan_table_t ATAN_TABLE = atanBuildTable();

endpackage

// File: rtl/atan_step.sv
// ---------------------------------------------------------------------------
// atan_step
// One combinational CORDIC vectoring micro-rotation. The rotation direction
// follows the sign of y, and a zero y leaves the vector and angle untouched.
//   i_x, i_y, i_z : current vector and accumulated angle (signed, ZW bits)
//   i_iter        : micro-rotation index, selects shift amount and angle
//   o_x, o_y, o_z : vector and angle after this micro-rotation
// ---------------------------------------------------------------------------
module atan_step
    import atan_pkg::*;
#(
    parameter int ZW = ATAN_ZW_DEFAULT
) (
    input  logic signed [ZW-1:0]         i_x,
    input  logic signed [ZW-1:0]         i_y,
    input  logic signed [ZW-1:0]         i_z,
    input  logic        [ATAN_IDX_W-1:0] i_iter,
    output logic signed [ZW-1:0]         o_x,
    output logic signed [ZW-1:0]         o_y,
    output logic signed [ZW-1:0]         o_z
);

    logic signed [ZW-1:0] w_xShift;
    logic signed [ZW-1:0] w_yShift;
    logic        [39:0]   w_tableEntry;
    logic signed [ZW-1:0] w_angle;

    assign w_xShift     = i_x >>> i_iter;
    assign w_yShift     = i_y >>> i_iter;
    // Indices past the table would only appear with an illegal ITER.
    assign w_tableEntry = (i_iter < ATAN_IDX_W'(ATAN_ENTRIES)) ? ATAN_TABLE[i_iter] : '0;
    assign w_angle      = ZW'(w_tableEntry);

    // Rotate toward the x axis: a positive y turns the vector clockwise and
    // adds the elementary angle, a negative y does the opposite. All sums
    // wrap at the datapath width.
    always_comb begin
        o_x = i_x;
        o_y = i_y;
        o_z = i_z;
        if (i_y[ZW-1]) begin
            o_x = i_x - w_yShift;
            o_y = i_y + w_xShift;
            o_z = i_z - w_angle;
        end else if (i_y != '0) begin
            o_x = i_x + w_yShift;
            o_y = i_y - w_xShift;
            o_z = i_z + w_angle;
        end
    end

endmodule

// File: rtl/atan_arbiter.sv
// ---------------------------------------------------------------------------
// atan_arbiter
// Two-requester round-robin front end for an iterative CORDIC arctangent.
// One operand pair is accepted at a time, run for ITER cycles and the result
// held until the consumer takes it.
//   clk, rst                     : clock, asynchronous active-high reset
//   req0_valid/ready, req0_inx/iny : requester 0 handshake and operands
//   req1_valid/ready, req1_inx/iny : requester 1 handshake and operands
//   out_valid/ready              : result handshake
//   out_id                       : requester that owns the result
//   out_angle                    : signed degrees, 8.24 fixed point
// ---------------------------------------------------------------------------
module atan_arbiter
    import atan_pkg::*;
#(
    parameter int ITER = ATAN_ITER_DEFAULT,
    parameter int ZW   = ATAN_ZW_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic signed [31:0] req0_inx,
    input  logic signed [31:0] req0_iny,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic signed [31:0] req1_inx,
    input  logic signed [31:0] req1_iny,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_id,
    output logic signed [31:0] out_angle
);

    localparam logic [ATAN_IDX_W-1:0] LAST_ITER = ATAN_IDX_W'(ITER - 1);

    atan_state_t                 r_state;
    logic signed [ZW-1:0]        r_x;
    logic signed [ZW-1:0]        r_y;
    logic signed [ZW-1:0]        r_z;
    logic        [ATAN_IDX_W-1:0] r_iter;
    logic                        r_lastGrant;

    logic                        w_idle;
    logic                        w_grant1;
    logic                        w_accept;
    logic signed [31:0]          w_inx;
    logic signed [31:0]          w_iny;
    logic signed [ZW-1:0]        w_xNext;
    logic signed [ZW-1:0]        w_yNext;
    logic signed [ZW-1:0]        w_zNext;

    // Round-robin choice: on a tie the requester not served last wins.
    // r_lastGrant resets to 1 so requester 0 takes the first tie.
    always_comb begin
        w_grant1 = req1_valid;
        if (req0_valid && req1_valid) begin
            w_grant1 = ~r_lastGrant;
        end
    end

    // Ready is masked by rst because the async reset already forces IDLE.
    assign w_idle     = (r_state == IDLE) && !rst;
    assign req0_ready = w_idle && req0_valid && !w_grant1;
    assign req1_ready = w_idle && req1_valid && w_grant1;
    assign w_accept   = req0_ready || req1_ready;
    assign w_inx      = w_grant1 ? req1_inx : req0_inx;
    assign w_iny      = w_grant1 ? req1_iny : req0_iny;

    atan_step #(
        .ZW(ZW)
    ) u_step (
        .i_x    (r_x),
        .i_y    (r_y),
        .i_z    (r_z),
        .i_iter (r_iter),
        .o_x    (w_xNext),
        .o_y    (w_yNext),
        .o_z    (w_zNext)
    );

    // Controller: load on handshake, one micro-rotation per RUN cycle, then
    // hold the registered result in DONE until the consumer accepts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_iter      <= '0;
            r_lastGrant <= 1'b1;
            out_valid   <= 1'b0;
            out_id      <= 1'b0;
            out_angle   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_x         <= {{(ZW-32){w_inx[31]}}, w_inx};
                        r_y         <= {{(ZW-32){w_iny[31]}}, w_iny};
                        r_z         <= '0;
                        r_iter      <= '0;
                        out_id      <= w_grant1;
                        r_lastGrant <= w_grant1;
                        r_state     <= RUN;
                    end
                end
                RUN: begin
                    r_x <= w_xNext;
                    r_y <= w_yNext;
                    r_z <= w_zNext;
                    if (r_iter == LAST_ITER) begin
                        out_angle <= w_zNext[ZW-1 -: 32];
                        out_valid <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_iter <= r_iter + ATAN_IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_atan_arbiter.sv
// ---------------------------------------------------------------------------
// tb_atan_arbiter
// Self-checking bench for atan_arbiter: directed cases with hand-computed
// angles plus a randomized run compared against a transaction-level model.
// ---------------------------------------------------------------------------
module tb_atan_arbiter;

    localparam int ITER       = 38;
    localparam int ZW         = 40;
    localparam int RAND_CYCLES = 3000;

    logic               clk = 1'b0;
    logic               rst;
    logic               req0_valid;
    logic               req0_ready;
    logic signed [31:0] req0_inx;
    logic signed [31:0] req0_iny;
    logic               req1_valid;
    logic               req1_ready;
    logic signed [31:0] req1_inx;
    logic signed [31:0] req1_iny;
    logic               out_valid;
    logic               out_ready;
    logic               out_id;
    logic signed [31:0] out_angle;

    int     nTests = 0;
    int     nFail  = 0;
    int     cycle  = 0;
    longint tbAtan [38];

    // Transaction-level model: busy flag, cycle the result must appear,
    // owner, expected angle and the last granted requester.
    bit     mBusy = 1'b0;
    bit     mLast = 1'b1;
    int     mDoneAt;
    bit     mId;
    bit     mDefined;
    int     mAngle;
    bit     eIdle, eG1, eR0, eR1, eValid;
    longint mX, mY;

    atan_arbiter #(
        .ITER(ITER),
        .ZW  (ZW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_inx   (req0_inx),
        .req0_iny   (req0_iny),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_inx   (req1_inx),
        .req1_iny   (req1_iny),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_id     (out_id),
        .out_angle  (out_angle)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Generic equality check with failure reporting.
    task automatic checkOutput(input string name, input longint actual, input longint expected);
        nTests++;
        if (actual != expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Angle check with a tolerance in output LSBs.
    task automatic checkNear(input string name, input longint actual, input longint expected, input longint tol);
        nTests++;
        if (actual > expected + tol || actual < expected - tol) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h +/- %0d",
                     name, actual[31:0], expected[31:0], tol);
        end
    endtask

    task automatic applyStimulus(input bit v0, input int x0, input int y0,
                                 input bit v1, input int x1, input int y1);
        req0_valid = v0;
        req0_inx   = x0;
        req0_iny   = y0;
        req1_valid = v1;
        req1_inx   = x1;
        req1_iny   = y1;
    endtask

    function automatic longint wrap40(input longint v);
        logic signed [39:0] t;
        t = v[39:0];
        return longint'(t);
    endfunction

    // Reference vectoring CORDIC in plain integer arithmetic with the
    // bench's own angle table; returns the top 32 bits of the angle.
    function automatic int refAngle(input longint x0, input longint y0);
        longint x, y, z, xs, ys;
        x = x0;
        y = y0;
        z = 0;
        for (int i = 0; i < ITER; i++) begin
            xs = x >>> i;
            ys = y >>> i;
            if (y > 0) begin
                x = wrap40(x + ys);
                y = wrap40(y - xs);
                z = wrap40(z + tbAtan[i]);
            end else if (y < 0) begin
                x = wrap40(x - ys);
                y = wrap40(y + xs);
                z = wrap40(z - tbAtan[i]);
            end
        end
        return int'(z >>> 8);
    endfunction

    function automatic int randX();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return -int'($urandom_range(0, 1000));
        if (r == 1) return int'($urandom_range(1, 16));
        return int'($urandom_range(1, 32'h7FFFFFFF));
    endfunction

    function automatic int randY();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 0;
        if (r == 1) return int'($urandom_range(0, 16)) - 8;
        return int'($urandom);
    endfunction

    // Per-cycle compare against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            checkOutput("rst req0_ready", req0_ready, 0);
            checkOutput("rst req1_ready", req1_ready, 0);
            checkOutput("rst out_valid", out_valid, 0);
            mBusy = 1'b0;
            mLast = 1'b1;
        end else begin
            eIdle  = !mBusy;
            eG1    = (req0_valid && req1_valid) ? !mLast : req1_valid;
            eR0    = eIdle && req0_valid && !eG1;
            eR1    = eIdle && req1_valid && eG1;
            eValid = mBusy && (cycle >= mDoneAt);
            checkOutput("req0_ready", req0_ready, eR0);
            checkOutput("req1_ready", req1_ready, eR1);
            checkOutput("out_valid", out_valid, eValid);
            if (eValid) begin
                checkOutput("out_id", out_id, mId);
                if (mDefined) checkNear("out_angle", out_angle, mAngle, 2);
                if (out_ready) mBusy = 1'b0;
            end
            if (eR0 || eR1) begin
                mBusy    = 1'b1;
                mDoneAt  = cycle + ITER + 1;
                mId      = eG1;
                mLast    = eG1;
                mX       = eG1 ? longint'(req1_inx) : longint'(req0_inx);
                mY       = eG1 ? longint'(req1_iny) : longint'(req0_iny);
                mDefined = (mX > 0);
                if (mDefined) mAngle = refAngle(mX, mY);
            end
        end
    end

    // Issues one request, waits for its result and checks latency/id/angle.
    // Returns at the mid-cycle point where out_valid was first seen.
    task automatic singleRequest(input string name, input bit who, input int x, input int y,
                                 input int expAngle, input int tol, output int tOut);
        int tAcc;
        tAcc = -1;
        tOut = -1;
        if (who) applyStimulus(1'b0, 0, 0, 1'b1, x, y);
        else     applyStimulus(1'b1, x, y, 1'b0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if ((who ? req1_ready : req0_ready) === 1'b1) begin
                tAcc = cycle;
                break;
            end
        end
        checkOutput({name, " accepted"}, tAcc >= 0, 1);
        @(posedge clk); #1;
        applyStimulus(1'b0, 0, 0, 1'b0, 0, 0);
        for (int k = 0; k < ITER + 10; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                tOut = cycle;
                break;
            end
        end
        checkOutput({name, " latency"}, tOut - tAcc, ITER + 1);
        checkOutput({name, " out_id"}, out_id, who);
        checkNear({name, " out_angle"}, out_angle, expAngle, tol);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  t0, res0, res1, firstR1, tOut, tAcc;
        real xr, scaled;
        longint v;

        // Bench-side angle table from the math library; 45 degrees is exact.
        xr = 1.0;
        for (int i = 0; i < 38; i++) begin
            scaled = $atan(xr) * 180.0 / 3.141592653589793 * 4294967296.0;
            v = longint'(scaled);
            if (real'(v) > scaled) v = v - 1;
            tbAtan[i] = v;
            xr = xr * 0.5;
        end
        tbAtan[0] = 64'd193273528320;

        // Reset with both requesters already asserting valid.
        rst       = 1'b1;
        out_ready = 1'b1;
        applyStimulus(1'b1, 1, 1, 1'b1, 1000, 0);
        repeat (3) @(posedge clk); #1;
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset out_id", out_id, 0);
        checkOutput("reset out_angle", out_angle, 0);
        checkOutput("reset req0_ready", req0_ready, 0);
        rst = 1'b0;

        // Tie straight out of reset: requester 0 first, then requester 1.
        t0 = -1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (req0_ready === 1'b1) begin
                t0 = cycle;
                break;
            end
        end
        checkOutput("tie first grant", t0 >= 0, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        res0 = -1;
        firstR1 = -1;
        for (int k = 0; k < 2 * ITER + 10; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1 && res0 < 0) begin
                res0 = cycle;
                checkOutput("tie result0 id", out_id, 0);
                checkNear("tie result0 angle", out_angle, 32'h2D000000, 4);
            end
            if (req1_ready === 1'b1) begin
                firstR1 = cycle;
                break;
            end
        end
        checkOutput("tie result0 latency", res0 - t0, ITER + 1);
        checkOutput("tie req1 grant cycle", firstR1 - res0, 1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        res1 = -1;
        for (int k = 0; k < ITER + 10; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                res1 = cycle;
                break;
            end
        end
        checkOutput("tie result1 latency", res1 - firstR1, ITER + 1);
        checkOutput("tie result1 id", out_id, 1);
        checkNear("tie result1 angle", out_angle, 0, 0);
        @(posedge clk); #1;

        // Directed single requests with hand-computed angles.
        singleRequest("req1 (1000,0)", 1'b1, 1000, 0, 0, 0, tOut);
        @(posedge clk); #1;
        singleRequest("req0 (1,1)", 1'b0, 1, 1, 32'h2D000000, 4, tOut);
        @(posedge clk); #1;
        singleRequest("req0 (1,-1)", 1'b0, 1, -1, 32'hD3000000, 4, tOut);
        @(posedge clk); #1;

        // Consumer stalls: result held, nothing accepted meanwhile.
        out_ready = 1'b0;
        singleRequest("hold", 1'b0, 1, 1, 32'h2D000000, 0, tOut);
        @(posedge clk); #1;
        applyStimulus(1'b1, 5, 5, 1'b1, 7, -7);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("hold out_valid", out_valid, 1);
            checkNear("hold out_angle", out_angle, 32'h2D000000, 0);
            checkOutput("hold req0_ready", req0_ready, 0);
            checkOutput("hold req1_ready", req1_ready, 0);
        end
        @(posedge clk); #1;
        applyStimulus(1'b0, 0, 0, 1'b0, 0, 0);
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("hold valid at release", out_valid, 1);
        @(posedge clk); #1;
        checkOutput("hold retired", out_valid, 0);

        // Reset while a result is waiting in DONE.
        out_ready = 1'b0;
        singleRequest("abort done", 1'b1, 5, 5, 32'h2D000000, 0, tOut);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkOutput("abort done out_valid", out_valid, 0);
        checkOutput("abort done out_id", out_id, 0);
        checkOutput("abort done out_angle", out_angle, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;

        // Reset at RUN iteration 10, then a tie must go to requester 0 again.
        applyStimulus(1'b1, 3, 4, 1'b0, 0, 0);
        tAcc = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req0_ready === 1'b1) begin
                tAcc = cycle;
                break;
            end
        end
        checkOutput("abort run accepted", tAcc >= 0, 1);
        @(posedge clk); #1;
        applyStimulus(1'b0, 0, 0, 1'b0, 0, 0);
        repeat (10) @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkOutput("abort run out_valid", out_valid, 0);
        checkOutput("abort run out_angle", out_angle, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus(1'b1, 1, 1, 1'b1, 1000, 0);
        @(negedge clk);
        checkOutput("post-reset tie req0_ready", req0_ready, 1);
        checkOutput("post-reset tie req1_ready", req1_ready, 0);
        tAcc = cycle;
        @(posedge clk); #1;
        applyStimulus(1'b0, 0, 0, 1'b0, 0, 0);
        tOut = -1;
        for (int k = 0; k < ITER + 10; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                tOut = cycle;
                break;
            end
        end
        checkOutput("post-reset latency", tOut - tAcc, ITER + 1);
        checkOutput("post-reset out_id", out_id, 0);
        checkNear("post-reset angle", out_angle, 32'h2D000000, 4);
        @(posedge clk); #1;

        // Randomized traffic; the compare process does the checking.
        for (int c = 0; c < RAND_CYCLES; c++) begin
            @(posedge clk); #1;
            rst        = (c >= 1500 && c < 1502);
            req0_valid = ($urandom_range(0, 99) < 60);
            req0_inx   = randX();
            req0_iny   = randY();
            req1_valid = ($urandom_range(0, 99) < 60);
            req1_inx   = randX();
            req1_iny   = randY();
            out_ready  = ($urandom_range(0, 99) < 75);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus(1'b0, 0, 0, 1'b0, 0, 0);
        out_ready = 1'b1;
        repeat (ITER + 5) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
